// File: rtl/wb_commit_buffer_if.sv
// Writeback handshake bundle: the memory-stage producer side and the register-file write side.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface wb_commit_buffer_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] port_data;
    logic          mem_sel;
    logic          port_sel;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic          rf_ready;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;

    modport slave (
        input  in_valid, mem_data, alu_data, port_data, mem_sel, port_sel, wr_en, rd_addr, rf_ready,
        output in_ready, rf_we, rf_addr, rf_data
    );

    modport master (
        output in_valid, mem_data, alu_data, port_data, mem_sel, port_sel, wr_en, rd_addr, rf_ready,
        input  in_ready, rf_we, rf_addr, rf_data
    );
endinterface

// File: rtl/wb_commit_buffer.sv
// Writeback commit FIFO; 1-cycle latency, or 0 when empty if WB_BYPASS_EN is defined.
// Backpressure: in_ready drops when full (from occupancy only); head holds while rf_ready is low.
module wb_commit_buffer #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_commit_buffer_if.slave    bus,
    input  logic                 flush,
    output logic [15:0]          commit_cnt
);
    localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] value;
        logic [AW-1:0] addr;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occ;
    logic [DW-1:0] sel_value;
    logic          not_empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          bypass;

    always_comb begin
        sel_value = bus.alu_data;
        if (bus.port_sel)
            sel_value = bus.port_data;
        else if (bus.mem_sel)
            sel_value = bus.mem_data;
    end

    assign not_empty    = (occ != '0);
    assign bus.in_ready = (occ < FULL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = not_empty && bus.rf_ready;

`ifdef WB_BYPASS_EN
    // Empty buffer and a ready register file: write straight through, nothing is stored.
    assign bypass = !not_empty && bus.in_valid && bus.wr_en && bus.rf_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // wr_en=0 entries are consumed but never occupy a slot.
    assign push      = accept && bus.wr_en && !flush && !bypass;
    assign bus.rf_we = pop || bypass;

    always_comb begin
        bus.rf_addr = '0;
        bus.rf_data = '0;
        if (not_empty) begin
            bus.rf_addr = mem[rd_ptr].addr;
            bus.rf_data = mem[rd_ptr].value;
        end else if (bypass) begin
            bus.rf_addr = bus.rd_addr;
            bus.rf_data = sel_value;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{value: sel_value, addr: bus.rd_addr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            commit_cnt <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
            end
            // A commit presented in a flush cycle still counts.
            if (bus.rf_we)
                commit_cnt <= commit_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed bench for wb_commit_buffer (DEPTH=2); expectations adapt to WB_BYPASS_EN.
module tb_wb_commit_buffer;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        vld;
        logic        we;
        logic [2:0]  rd;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [15:0] prt;
        logic        msel;
        logic        psel;
        logic        fl;
        logic        rr;
        logic        e_ir;
        logic        e_we;
        logic [2:0]  e_a;
        logic [15:0] e_d;
        logic [15:0] e_c;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [15:0] commit_cnt;
    int          n_vec;
    int          n_miss;
    vec_t        tbl[$];

    wb_commit_buffer_if #(.DW(16), .AW(3)) bus ();

    wb_commit_buffer #(.DW(16), .AW(3), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .commit_cnt (commit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic vld, input logic we, input logic [2:0] rd,
                                input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] prt,
                                input logic msel, input logic psel, input logic fl, input logic rr,
                                input logic e_ir, input logic e_we, input logic [2:0] e_a,
                                input logic [15:0] e_d, input logic [15:0] e_c);
        vec_t v;
        v.vld = vld; v.we = we; v.rd = rd; v.alu = alu; v.mem = mem; v.prt = prt;
        v.msel = msel; v.psel = psel; v.fl = fl; v.rr = rr;
        v.e_ir = e_ir; v.e_we = e_we; v.e_a = e_a; v.e_d = e_d; v.e_c = e_c;
        return v;
    endfunction

    task automatic drive(input logic vld, input logic we, input logic [2:0] rd, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [15:0] prt, input logic msel,
                         input logic psel, input logic fl, input logic rr);
        bus.in_valid  = vld;
        bus.wr_en     = we;
        bus.rd_addr   = rd;
        bus.alu_data  = alu;
        bus.mem_data  = mem;
        bus.port_data = prt;
        bus.mem_sel   = msel;
        bus.port_sel  = psel;
        flush         = fl;
        bus.rf_ready  = rr;
    endtask

    task automatic chk(input string name, input logic [36:0] exp);
        logic [36:0] got;
        got = {bus.in_ready, bus.rf_we, bus.rf_addr, bus.rf_data, commit_cnt};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got ir/we/a/d/cnt=%b/%b/%0d/%h/%h, expected %b/%b/%0d/%h/%h",
                     name, got[36], got[35], got[34:32], got[31:16], got[15:0],
                     exp[36], exp[35], exp[34:32], exp[31:16], exp[15:0]);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //              vld we rd alu      mem      prt      ms ps fl rr | ir we  a                 d                          cnt
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 0,  1, 0,    3'd0,           16'h0,                   16'd0));
        tbl.push_back(mk(1, 1, 5, 16'h1234, 16'h0,    16'h0,    0, 0, 0, 1,  1, BYP,  BYP ? 3'd5 : 3'd0, BYP ? 16'h1234 : 16'h0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, !BYP, BYP ? 3'd0 : 3'd5, BYP ? 16'h0 : 16'h1234, BYP ? 16'd1 : 16'd0));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, 0,    3'd0,           16'h0,                   16'd1));
        tbl.push_back(mk(1, 1, 2, 16'h1111, 16'hAAAA, 16'hBEEF, 1, 1, 0, 0,  1, 0,    3'd0,           16'h0,                   16'd1));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, 1,    3'd2,           16'hBEEF,                16'd1));
        tbl.push_back(mk(1, 1, 3, 16'h1111, 16'hAAAA, 16'h0,    1, 0, 0, 0,  1, 0,    3'd0,           16'h0,                   16'd2));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 0,  1, 0,    3'd3,           16'hAAAA,                16'd2));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, 1,    3'd3,           16'hAAAA,                16'd2));
        tbl.push_back(mk(1, 0, 4, 16'h5555, 16'h0,    16'h0,    0, 0, 0, 1,  1, 0,    3'd0,           16'h0,                   16'd3));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, 0,    3'd0,           16'h0,                   16'd3));
        tbl.push_back(mk(1, 1, 1, 16'h0101, 16'h0,    16'h0,    0, 0, 0, 0,  1, 0,    3'd0,           16'h0,                   16'd3));
        tbl.push_back(mk(1, 1, 2, 16'h0202, 16'h0,    16'h0,    0, 0, 0, 0,  1, 0,    3'd1,           16'h0101,                16'd3));
        tbl.push_back(mk(1, 1, 3, 16'h0303, 16'h0,    16'h0,    0, 0, 0, 0,  0, 0,    3'd1,           16'h0101,                16'd3));
        tbl.push_back(mk(1, 1, 3, 16'h0303, 16'h0,    16'h0,    0, 0, 0, 1,  0, 1,    3'd1,           16'h0101,                16'd3));
        tbl.push_back(mk(1, 1, 3, 16'h0303, 16'h0,    16'h0,    0, 0, 0, 1,  1, 1,    3'd2,           16'h0202,                16'd4));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, 1,    3'd3,           16'h0303,                16'd5));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, 0,    3'd0,           16'h0,                   16'd6));
        tbl.push_back(mk(1, 1, 6, 16'h0606, 16'h0,    16'h0,    0, 0, 0, 0,  1, 0,    3'd0,           16'h0,                   16'd6));
        tbl.push_back(mk(1, 1, 7, 16'h0707, 16'h0,    16'h0,    0, 0, 0, 0,  1, 0,    3'd6,           16'h0606,                16'd6));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 1, 0,  0, 0,    3'd6,           16'h0606,                16'd6));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, 0,    3'd0,           16'h0,                   16'd6));
        tbl.push_back(mk(1, 1, 1, 16'h0011, 16'h0,    16'h0,    0, 0, 0, 0,  1, 0,    3'd0,           16'h0,                   16'd6));
        tbl.push_back(mk(1, 1, 2, 16'h0022, 16'h0,    16'h0,    0, 0, 1, 1,  1, 1,    3'd1,           16'h0011,                16'd6));
        tbl.push_back(mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 0, 0, 1,  1, 0,    3'd0,           16'h0,                   16'd7));

        #12 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].vld, tbl[i].we, tbl[i].rd, tbl[i].alu, tbl[i].mem, tbl[i].prt,
                  tbl[i].msel, tbl[i].psel, tbl[i].fl, tbl[i].rr);
            #1 chk($sformatf("vec%0d", i),
                   {tbl[i].e_ir, tbl[i].e_we, tbl[i].e_a, tbl[i].e_d, tbl[i].e_c});
        end

        // Counter wrap: 65528 more commits take it from 7 to 0xFFFF.
        for (int i = 0; i < 65528; i++) begin
            @(negedge clk);
            drive(1, 1, 3'(i), 16'(i), 0, 0, 0, 0, 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1 chk("cnt_ffff", {1'b1, 1'b0, 3'd0, 16'h0, 16'hFFFF});

        // Zero-latency bypass versus one-cycle buffered commit; this commit also wraps the counter.
        @(negedge clk);
        drive(1, 1, 7, 16'h0042, 0, 0, 0, 0, 0, 1);
        #1 chk("bypass_same_cycle", {1'b1, BYP, BYP ? 3'd7 : 3'd0, BYP ? 16'h0042 : 16'h0, 16'hFFFF});
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("bypass_next_cycle", {1'b1, !BYP, BYP ? 3'd0 : 3'd7, BYP ? 16'h0 : 16'h0042,
                                     BYP ? 16'h0000 : 16'hFFFF});
        @(negedge clk);
        #1 chk("cnt_wrap", {1'b1, 1'b0, 3'd0, 16'h0, 16'h0000});

        // Asynchronous reset with two entries buffered: everything is lost, nothing commits.
        @(negedge clk);
        drive(1, 1, 5, 16'h5555, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 6, 16'h6666, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("pre_reset_head", {1'b0, 1'b1, 3'd5, 16'h5555, 16'h0000});
        #1 rst_n = 1'b0;
        #1 chk("async_reset", {1'b1, 1'b0, 3'd0, 16'h0, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("post_reset_idle", {1'b1, 1'b0, 3'd0, 16'h0, 16'h0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
